// File: rtl/traffic_pkg.sv
// Shared definitions between the request frontend and the 4-way light controller.
package traffic_pkg;

    localparam int NUM_DIR = 4;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        DONE    = 2'd3
    } req_state_e;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NUM_DIR-1:0] v);
        return (v & (v - NUM_DIR'(1))) != '0;
    endfunction

endpackage

// File: rtl/traffic_debounce.sv
// Single-bit two-flop synchroniser followed by a consecutive-cycle debounce filter.
module traffic_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_i,
    output logic deb_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;

    // The synchroniser keeps running with ena low so the filter resumes on fresh data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (ena) begin
                if (sync2_q != deb_q) begin
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q <= sync2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/traffic_request_frontend.sv
// Debounced per-direction request latching, served-request retirement,
// starvation reporting and multi-green detection.
module traffic_request_frontend
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CLEAR_HOLD      = 4,
    parameter int MAX_WAIT        = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               tick,
    input  logic [NUM_DIR-1:0] sensor_raw,
    input  logic [NUM_DIR-1:0] light_green,
    output logic [NUM_DIR-1:0] req_out,
    output logic [NUM_DIR-1:0] starve,
    output logic               conflict_err
);

    localparam int HW = $clog2(CLEAR_HOLD + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [NUM_DIR-1:0] deb;
    logic               conflict_q;

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_dir
        req_state_e    state_q, state_d;
        logic [HW-1:0] hold_q, hold_d;
        logic [WW-1:0] wait_q, wait_d;
        logic          req_q;
        logic          starve_q;

        traffic_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (ena),
            .raw_i (sensor_raw[i]),
            .deb_o (deb[i])
        );

        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            wait_d  = wait_q;
            case (state_q)
                IDLE: begin
                    if (deb[i]) state_d = PENDING;
                end
                PENDING: begin
                    if (tick && (wait_q != WW'(MAX_WAIT))) wait_d = wait_q + WW'(1);
                    if (light_green[i]) begin
                        if (CLEAR_HOLD <= 1) begin
                            state_d = DONE;
                        end else begin
                            state_d = SERVING;
                            hold_d  = HW'(1);
                        end
                    end
                end
                SERVING: begin
                    if (!light_green[i]) begin
                        state_d = PENDING;
                        hold_d  = '0;
                    end else if (int'(hold_q) + 1 >= CLEAR_HOLD) begin
                        state_d = DONE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                DONE: begin
                    if (!light_green[i]) state_d = deb[i] ? PENDING : IDLE;
                end
                default: state_d = IDLE;
            endcase
            if ((state_d == IDLE) || (state_d == DONE)) wait_d = '0;
        end

        // Outputs are decoded from next-state so they line up with the state flops.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                hold_q   <= '0;
                wait_q   <= '0;
                req_q    <= 1'b0;
                starve_q <= 1'b0;
            end else if (ena) begin
                state_q  <= state_d;
                hold_q   <= hold_d;
                wait_q   <= wait_d;
                req_q    <= (state_d == PENDING) || (state_d == SERVING);
                starve_q <= (wait_d >= WW'(MAX_WAIT));
            end
        end

        assign req_out[i] = req_q;
        assign starve[i]  = starve_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else if (ena && multi_hot(light_green)) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict_err = conflict_q;

endmodule

// File: tb/tb_traffic_request_frontend.sv
// Directed bench for traffic_request_frontend with small parameters.
module tb_traffic_request_frontend;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       tick;
    logic [3:0] sensor_raw;
    logic [3:0] light_green;
    logic [3:0] req_out;
    logic [3:0] starve;
    logic       conflict_err;

    int checks = 0;
    int errors = 0;

    traffic_request_frontend #(
        .DEBOUNCE_CYCLES (4),
        .CLEAR_HOLD      (4),
        .MAX_WAIT        (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .tick         (tick),
        .sensor_raw   (sensor_raw),
        .light_green  (light_green),
        .req_out      (req_out),
        .starve       (starve),
        .conflict_err (conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ena         = 1'b1;
        tick        = 1'b0;
        sensor_raw  = 4'b0000;
        light_green = 4'b0000;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        ena         = 1'b1;
        tick        = 1'b0;
        sensor_raw  = 4'b1111;
        light_green = 4'b0101;
        cyc(2);
        checks++;
        if (req_out !== 4'b0000) begin
            errors++; $display("FAIL reset_req got %b expected 0000", req_out);
        end
        checks++;
        if (starve !== 4'b0000) begin
            errors++; $display("FAIL reset_starve got %b expected 0000", starve);
        end
        checks++;
        if (conflict_err !== 1'b0) begin
            errors++; $display("FAIL reset_conflict got %b expected 0", conflict_err);
        end
        sensor_raw  = 4'b0000;
        light_green = 4'b0000;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [3:0] exp;
        do_reset();
        sensor_raw = 4'b0001;
        for (int e = 1; e <= 9; e++) begin
            cyc();
            exp = (e >= 7) ? 4'b0001 : 4'b0000;
            checks++;
            if (req_out !== exp) begin
                errors++; $display("FAIL latency_edge%0d got %b expected %b", e, req_out, exp);
            end
        end
        checks++;
        if (starve !== 4'b0000 || conflict_err !== 1'b0) begin
            errors++; $display("FAIL latency_side got starve=%b conflict=%b expected 0000/0", starve, conflict_err);
        end
    endtask

    task automatic test_glitch();
        sensor_raw = 4'b0101;
        cyc(3);
        sensor_raw = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            checks++;
            if (req_out !== 4'b0001) begin
                errors++; $display("FAIL glitch_edge%0d got %b expected 0001", e, req_out);
            end
        end
    endtask

    task automatic test_service();
        sensor_raw = 4'b0011;
        cyc(7);
        checks++;
        if (req_out !== 4'b0011) begin
            errors++; $display("FAIL service_pending got %b expected 0011", req_out);
        end
        light_green = 4'b0010;
        for (int e = 1; e <= 3; e++) begin
            cyc();
            checks++;
            if (req_out[1] !== 1'b1) begin
                errors++; $display("FAIL service_short%0d got %b expected 1", e, req_out[1]);
            end
        end
        light_green = 4'b0000;
        cyc();
        checks++;
        if (req_out[1] !== 1'b1) begin
            errors++; $display("FAIL service_early_drop got %b expected 1", req_out[1]);
        end
        light_green = 4'b0010;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            checks++;
            if (req_out[1] !== (e < 4)) begin
                errors++; $display("FAIL service_full%0d got %b expected %b", e, req_out[1], (e < 4));
            end
        end
        light_green = 4'b0000;
        cyc();
        checks++;
        if (req_out !== 4'b0011) begin
            errors++; $display("FAIL service_rerequest got %b expected 0011", req_out);
        end
    endtask

    task automatic test_starve();
        logic [3:0] exp;
        do_reset();
        sensor_raw = 4'b0001;
        cyc(7);
        for (int k = 1; k <= 6; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            exp = (k >= 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (starve !== exp) begin
                errors++; $display("FAIL starve_tick%0d got %b expected %b", k, starve, exp);
            end
            cyc();
        end
        sensor_raw = 4'b0000;
        cyc(8);
        checks++;
        if (req_out !== 4'b0001 || starve !== 4'b0001) begin
            errors++; $display("FAIL starve_persist got req=%b starve=%b expected 0001/0001", req_out, starve);
        end
        light_green = 4'b0001;
        cyc();
        checks++;
        if (starve !== 4'b0001) begin
            errors++; $display("FAIL starve_serving got %b expected 0001", starve);
        end
        cyc(3);
        checks++;
        if (starve !== 4'b0000 || req_out !== 4'b0000) begin
            errors++; $display("FAIL starve_done got starve=%b req=%b expected 0000/0000", starve, req_out);
        end
        light_green = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
        checks++;
        if (starve !== 4'b0000 || req_out !== 4'b0000) begin
            errors++; $display("FAIL starve_idle got starve=%b req=%b expected 0000/0000", starve, req_out);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        ena         = 1'b0;
        light_green = 4'b0011;
        cyc();
        light_green = 4'b0000;
        ena         = 1'b1;
        cyc();
        checks++;
        if (conflict_err !== 1'b0) begin
            errors++; $display("FAIL conflict_ena_low got %b expected 0", conflict_err);
        end
        light_green = 4'b0101;
        cyc();
        light_green = 4'b0000;
        checks++;
        if (conflict_err !== 1'b1) begin
            errors++; $display("FAIL conflict_set got %b expected 1", conflict_err);
        end
        cyc(3);
        checks++;
        if (conflict_err !== 1'b1) begin
            errors++; $display("FAIL conflict_sticky got %b expected 1", conflict_err);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if (conflict_err !== 1'b0) begin
            errors++; $display("FAIL conflict_reset got %b expected 0", conflict_err);
        end
    endtask

    task automatic test_ena_reset();
        do_reset();
        sensor_raw = 4'b0100;
        cyc(7);
        checks++;
        if (req_out !== 4'b0100) begin
            errors++; $display("FAIL ena_pending got %b expected 0100", req_out);
        end
        light_green = 4'b0100;
        cyc(2);
        ena = 1'b0;
        cyc(10);
        checks++;
        if (req_out !== 4'b0100) begin
            errors++; $display("FAIL ena_frozen got %b expected 0100", req_out);
        end
        ena = 1'b1;
        cyc();
        checks++;
        if (req_out !== 4'b0100) begin
            errors++; $display("FAIL ena_hold3 got %b expected 0100", req_out);
        end
        cyc();
        checks++;
        if (req_out !== 4'b0000) begin
            errors++; $display("FAIL ena_done got %b expected 0000", req_out);
        end
        light_green = 4'b0000;
        cyc();
        checks++;
        if (req_out !== 4'b0100) begin
            errors++; $display("FAIL ena_rerequest got %b expected 0100", req_out);
        end
        rst_n = 1'b0;
        cyc();
        checks++;
        if (req_out !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_pending got %b expected 0000", req_out);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        tick        = 1'b0;
        sensor_raw  = 4'b0000;
        light_green = 4'b0000;
        test_reset();
        test_latency();
        test_glitch();
        test_service();
        test_starve();
        test_conflict();
        test_ena_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
